// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_gen_pkg;

    // Sequencer phases: waiting, start delay, pulse high, inter-pulse low
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } pulse_state_t;

    // Values of the mode input
    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_CONT  = 1'b1;

endpackage

// File: rtl/pulse_phase_counter.sv
// Loadable down-counter that times the DELAY, HIGH and LOW phases.
// Loading value V gives a zero flag after V further cycles, so a phase of
// length N is timed by loading N-1 on the edge that enters it.
module pulse_phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down and rest at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Cycle-accurate pulse train generator with programmable start delay,
// high time, low time and pulse count, in burst or continuous mode.
// The FSM state drives the phase counter directly; every output is a
// register fed from the current state, so outputs trail the state by one
// cycle and no input reaches an output combinationally. The delay phase
// is therefore D state cycles long (skipped entirely when D is 0), which
// puts the first high output D+1 cycles after the start sample.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enab,
    input  logic             mode,
    input  logic [NUM_W-1:0] n_pulses,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    output logic             pulses,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    pulse_state_t state;
    pulse_state_t next_state;

    logic             enab_q;
    logic             start_evt;

    // Configuration captured on the start cycle (lengths stored as length-1)
    logic             cfg_mode;
    logic [CNT_W-1:0] cfg_high_m1;
    logic [CNT_W-1:0] cfg_low_m1;

    // Live-input versions of the same lengths, used on the start cycle itself
    logic [CNT_W-1:0] high_m1_in;
    logic [CNT_W-1:0] low_m1_in;
    logic [CNT_W-1:0] delay_m1_in;

    logic [NUM_W-1:0] remaining;
    logic             stop_req;

    logic             phase_load;
    logic [CNT_W-1:0] phase_value;
    logic             phase_zero;

    logic             finish;
    logic             finish_q;
    logic             pulses_d;
    logic             busy_d;

    // A zero length behaves as one cycle, so both map to a count of 0
    assign high_m1_in  = (high_len == '0) ? '0 : high_len - CNT_W'(1);
    assign low_m1_in   = (low_len  == '0) ? '0 : low_len  - CNT_W'(1);
    assign delay_m1_in = delay - CNT_W'(1);

    // Rising edges of enab only count while the generator is idle
    assign start_evt = (state == IDLE) && enab && !enab_q;

    pulse_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (phase_load),
        .value (phase_value),
        .zero  (phase_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and detection of a normal completion
    always_comb begin
        next_state = state;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_evt) begin
                    if ((mode == MODE_BURST) && (n_pulses == '0)) begin
                        finish = 1'b1;
                    end else if (delay == '0) begin
                        next_state = HIGH;
                    end else begin
                        next_state = DELAY;
                    end
                end
            end
            DELAY: begin
                if ((cfg_mode == MODE_CONT) && !enab) begin
                    next_state = IDLE;
                end else if (phase_zero) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (phase_zero) begin
                    if (cfg_mode == MODE_BURST) begin
                        if (remaining == NUM_W'(1)) begin
                            next_state = IDLE;
                            finish     = 1'b1;
                        end else begin
                            next_state = LOW;
                        end
                    end else if (!enab) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end else begin
                        next_state = LOW;
                    end
                end
            end
            LOW: begin
                if (phase_zero) begin
                    if ((cfg_mode == MODE_CONT) && (stop_req || !enab)) begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end else begin
                        next_state = HIGH;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: phase counter reload and the next values of the outputs
    always_comb begin
        phase_load  = (next_state != state);
        phase_value = '0;
        case (next_state)
            DELAY:   phase_value = delay_m1_in;
            HIGH:    phase_value = (state == IDLE) ? high_m1_in : cfg_high_m1;
            LOW:     phase_value = cfg_low_m1;
            default: phase_value = '0;
        endcase
        pulses_d = (state == HIGH);
        busy_d   = (state != IDLE);
    end

    // Edge detector history and start-cycle configuration capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enab_q      <= 1'b0;
            cfg_mode    <= MODE_BURST;
            cfg_high_m1 <= '0;
            cfg_low_m1  <= '0;
        end else begin
            enab_q <= enab;
            if (start_evt) begin
                cfg_mode    <= mode;
                cfg_high_m1 <= high_m1_in;
                cfg_low_m1  <= low_m1_in;
            end
        end
    end

    // Burst remaining-pulse counter and continuous-mode stop request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
            stop_req  <= 1'b0;
        end else begin
            if (start_evt) begin
                remaining <= n_pulses;
            end else if ((state == HIGH) && (next_state == LOW)) begin
                remaining <= remaining - NUM_W'(1);
            end
            if (start_evt) begin
                stop_req <= 1'b0;
            end else if ((state == LOW) && (cfg_mode == MODE_CONT) && !enab) begin
                stop_req <= 1'b1;
            end
        end
    end

    // Saturating count of pulses, cleared on start and bumped on HIGH entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
        end else if (start_evt) begin
            pulse_cnt <= (next_state == HIGH) ? NUM_W'(1) : '0;
        end else if ((next_state == HIGH) && (state != HIGH)) begin
            if (pulse_cnt != '1) begin
                pulse_cnt <= pulse_cnt + NUM_W'(1);
            end
        end
    end

    // Registered outputs; done is delayed so it lands as pulses falls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulses   <= 1'b0;
            busy     <= 1'b0;
            finish_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            pulses   <= pulses_d;
            busy     <= busy_d;
            finish_q <= finish;
            done     <= finish_q;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed testbench for pulse_train_gen. Cycle c means the value seen
// after the c-th rising edge counted from the edge that samples the start.
module tb_pulse_train_gen;

    logic        clk;
    logic        rst_n;
    logic        enab;
    logic        mode;
    logic [7:0]  n_pulses;
    logic [15:0] delay;
    logic [15:0] high_len;
    logic [15:0] low_len;
    logic        pulses;
    logic        busy;
    logic        done;
    logic [7:0]  pulse_cnt;

    logic        sat_enab;
    logic        sat_mode;
    logic [1:0]  sat_n_pulses;
    logic [15:0] sat_delay;
    logic [15:0] sat_high_len;
    logic [15:0] sat_low_len;
    logic        sat_pulses;
    logic        sat_busy;
    logic        sat_done;
    logic [1:0]  sat_pulse_cnt;

    int checks;
    int errors;

    pulse_train_gen #(
        .CNT_W (16),
        .NUM_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enab      (enab),
        .mode      (mode),
        .n_pulses  (n_pulses),
        .delay     (delay),
        .high_len  (high_len),
        .low_len   (low_len),
        .pulses    (pulses),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    pulse_train_gen #(
        .CNT_W (16),
        .NUM_W (2)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .enab      (sat_enab),
        .mode      (sat_mode),
        .n_pulses  (sat_n_pulses),
        .delay     (sat_delay),
        .high_len  (sat_high_len),
        .low_len   (sat_low_len),
        .pulses    (sat_pulses),
        .busy      (sat_busy),
        .done      (sat_done),
        .pulse_cnt (sat_pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_cycles(input int n);
        enab = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pulses !== 1'b0) begin errors++; $display("[TB] FAIL reset.pulses got %b exp 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset.done got %b exp 0", done); end
        checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset.pulse_cnt got %0d exp 0", pulse_cnt); end
        checks++; if (sat_pulse_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset.sat_pulse_cnt got %0d exp 0", sat_pulse_cnt); end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic_burst();
        logic ep, eb, ed;
        $display("[TB] basic burst");
        idle_cycles(2);
        mode = 1'b0; n_pulses = 8'd3; delay = 16'd2; high_len = 16'd3; low_len = 16'd2;
        enab = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            ep = (c >= 3 && c <= 5) || (c >= 8 && c <= 10) || (c >= 13 && c <= 15);
            eb = (c >= 1 && c <= 15);
            ed = (c == 16);
            checks++; if (pulses !== ep) begin errors++; $display("[TB] FAIL basic.pulses c=%0d got %b exp %b", c, pulses, ep); end
            checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL basic.busy c=%0d got %b exp %b", c, busy, eb); end
            checks++; if (done !== ed) begin errors++; $display("[TB] FAIL basic.done c=%0d got %b exp %b", c, done, ed); end
        end
        checks++; if (pulse_cnt !== 8'd3) begin errors++; $display("[TB] FAIL basic.pulse_cnt got %0d exp 3", pulse_cnt); end
        idle_cycles(2);
    endtask

    task automatic test_zero_count();
        logic ed;
        $display("[TB] zero pulse count");
        idle_cycles(2);
        mode = 1'b0; n_pulses = 8'd0; delay = 16'd3; high_len = 16'd2; low_len = 16'd2;
        enab = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            ed = (c == 1);
            checks++; if (pulses !== 1'b0) begin errors++; $display("[TB] FAIL zcount.pulses c=%0d got %b exp 0", c, pulses); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zcount.busy c=%0d got %b exp 0", c, busy); end
            checks++; if (done !== ed) begin errors++; $display("[TB] FAIL zcount.done c=%0d got %b exp %b", c, done, ed); end
        end
        checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("[TB] FAIL zcount.pulse_cnt got %0d exp 0", pulse_cnt); end
        idle_cycles(2);
    endtask

    task automatic test_zero_lengths();
        logic ep, eb, ed;
        $display("[TB] zero lengths");
        idle_cycles(2);
        mode = 1'b0; n_pulses = 8'd2; delay = 16'd0; high_len = 16'd0; low_len = 16'd0;
        enab = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            ep = (c == 1) || (c == 3);
            eb = (c >= 1 && c <= 3);
            ed = (c == 4);
            checks++; if (pulses !== ep) begin errors++; $display("[TB] FAIL zlen.pulses c=%0d got %b exp %b", c, pulses, ep); end
            checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL zlen.busy c=%0d got %b exp %b", c, busy, eb); end
            checks++; if (done !== ed) begin errors++; $display("[TB] FAIL zlen.done c=%0d got %b exp %b", c, done, ed); end
        end
        checks++; if (pulse_cnt !== 8'd2) begin errors++; $display("[TB] FAIL zlen.pulse_cnt got %0d exp 2", pulse_cnt); end
        idle_cycles(2);
    endtask

    task automatic test_cont_stop();
        logic ep, eb, ed;
        $display("[TB] continuous stop");
        idle_cycles(2);
        mode = 1'b1; n_pulses = 8'd0; delay = 16'd0; high_len = 16'd4; low_len = 16'd4;
        enab = 1'b1;
        for (int c = 0; c <= 23; c++) begin
            @(negedge clk);
            ep = (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 20);
            eb = (c >= 1 && c <= 20);
            ed = (c == 21);
            checks++; if (pulses !== ep) begin errors++; $display("[TB] FAIL cstop.pulses c=%0d got %b exp %b", c, pulses, ep); end
            checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL cstop.busy c=%0d got %b exp %b", c, busy, eb); end
            checks++; if (done !== ed) begin errors++; $display("[TB] FAIL cstop.done c=%0d got %b exp %b", c, done, ed); end
            if (c == 18) enab = 1'b0;
        end
        checks++; if (pulse_cnt !== 8'd3) begin errors++; $display("[TB] FAIL cstop.pulse_cnt got %0d exp 3", pulse_cnt); end
        idle_cycles(2);
    endtask

    task automatic test_cont_delay_abort();
        logic eb;
        $display("[TB] continuous abort in delay");
        idle_cycles(2);
        mode = 1'b1; n_pulses = 8'd0; delay = 16'd5; high_len = 16'd2; low_len = 16'd2;
        enab = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            eb = (c == 1) || (c == 2);
            checks++; if (pulses !== 1'b0) begin errors++; $display("[TB] FAIL dabort.pulses c=%0d got %b exp 0", c, pulses); end
            checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL dabort.busy c=%0d got %b exp %b", c, busy, eb); end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dabort.done c=%0d got %b exp 0", c, done); end
            if (c == 1) enab = 1'b0;
        end
        checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("[TB] FAIL dabort.pulse_cnt got %0d exp 0", pulse_cnt); end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        logic ep, eb, ed;
        $display("[TB] retrigger and config change");
        idle_cycles(2);
        mode = 1'b0; n_pulses = 8'd2; delay = 16'd1; high_len = 16'd3; low_len = 16'd2;
        enab = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            ep = (c >= 2 && c <= 4) || (c >= 7 && c <= 9);
            eb = (c >= 1 && c <= 9);
            ed = (c == 10);
            checks++; if (pulses !== ep) begin errors++; $display("[TB] FAIL retrig.pulses c=%0d got %b exp %b", c, pulses, ep); end
            checks++; if (busy !== eb) begin errors++; $display("[TB] FAIL retrig.busy c=%0d got %b exp %b", c, busy, eb); end
            checks++; if (done !== ed) begin errors++; $display("[TB] FAIL retrig.done c=%0d got %b exp %b", c, done, ed); end
            if (c == 2) enab = 1'b0;
            if (c == 4) begin
                enab = 1'b1;
                high_len = 16'd7;
            end
        end
        checks++; if (pulse_cnt !== 8'd2) begin errors++; $display("[TB] FAIL retrig.pulse_cnt got %0d exp 2", pulse_cnt); end
        idle_cycles(2);
        n_pulses = 8'd1; delay = 16'd0;
        enab = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            ep = (c >= 1 && c <= 7);
            ed = (c == 8);
            checks++; if (pulses !== ep) begin errors++; $display("[TB] FAIL newcfg.pulses c=%0d got %b exp %b", c, pulses, ep); end
            checks++; if (done !== ed) begin errors++; $display("[TB] FAIL newcfg.done c=%0d got %b exp %b", c, done, ed); end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_train();
        logic ep;
        logic found;
        $display("[TB] reset mid-train");
        idle_cycles(2);
        mode = 1'b0; n_pulses = 8'd3; delay = 16'd0; high_len = 16'd5; low_len = 16'd1;
        enab = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
        end
        checks++; if (pulses !== 1'b1) begin errors++; $display("[TB] FAIL rstmid.pre_pulses got %b exp 1", pulses); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (pulses !== 1'b0) begin errors++; $display("[TB] FAIL rstmid.pulses got %b exp 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid.busy got %b exp 0", busy); end
        checks++; if (pulse_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rstmid.pulse_cnt got %0d exp 0", pulse_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid.done got %b exp 0", done); end
        rst_n = 1'b1;
        for (int r = 0; r <= 7; r++) begin
            @(negedge clk);
            ep = (r >= 1 && r <= 5) || (r == 7);
            checks++; if (pulses !== ep) begin errors++; $display("[TB] FAIL rstrel.pulses r=%0d got %b exp %b", r, pulses, ep); end
            checks++; if (busy !== (r >= 1)) begin errors++; $display("[TB] FAIL rstrel.busy r=%0d got %b exp %b", r, busy, (r >= 1)); end
        end
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rstrel.done_timeout got %b exp 1", found); end
        checks++; if (pulse_cnt !== 8'd3) begin errors++; $display("[TB] FAIL rstrel.pulse_cnt got %0d exp 3", pulse_cnt); end
        idle_cycles(2);
    endtask

    task automatic test_saturation();
        logic [1:0] ec;
        logic found;
        $display("[TB] pulse count saturation");
        sat_mode = 1'b1; sat_n_pulses = 2'd0; sat_delay = 16'd0; sat_high_len = 16'd1; sat_low_len = 16'd1;
        sat_enab = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            ec = (c >= 4) ? 2'd3 : 2'(c / 2 + 1);
            checks++; if (sat_pulse_cnt !== ec) begin errors++; $display("[TB] FAIL sat.pulse_cnt c=%0d got %0d exp %0d", c, sat_pulse_cnt, ec); end
            checks++; if (sat_pulses !== ((c % 2) == 1)) begin errors++; $display("[TB] FAIL sat.pulses c=%0d got %b exp %b", c, sat_pulses, ((c % 2) == 1)); end
        end
        sat_enab = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (sat_done) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL sat.done_timeout got %b exp 1", found); end
        checks++; if (sat_pulse_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat.final_cnt got %0d exp 3", sat_pulse_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        enab = 1'b0; mode = 1'b0; n_pulses = 8'd0; delay = 16'd0; high_len = 16'd0; low_len = 16'd0;
        sat_enab = 1'b0; sat_mode = 1'b0; sat_n_pulses = 2'd0; sat_delay = 16'd0; sat_high_len = 16'd0; sat_low_len = 16'd0;
        test_reset();
        test_basic_burst();
        test_zero_count();
        test_zero_lengths();
        test_cont_stop();
        test_cont_delay_abort();
        test_back_to_back();
        test_reset_mid_train();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
